// File: rtl/vga_pkg.sv
// Shared VGA constants, colour types and helpers.
//   H_DRAW_MIN / ACTIVE_W / ACTIVE_H : visible 640x480 window geometry
//   FB_W / FB_H / FB_AW               : 320x240 framebuffer and its address width
//   R_*/G_*/B_* bit positions         : RGB332 field layout in a framebuffer byte
//   bar_index / bar_colour            : 8-bar test pattern lookup
//   rgb332_expand                     : RGB332 byte to 12-bit colour
package vga_pkg;

    localparam int unsigned H_DRAW_MIN = 160;
    localparam int unsigned ACTIVE_W   = 640;
    localparam int unsigned ACTIVE_H   = 480;

    localparam int unsigned FB_W  = 320;
    localparam int unsigned FB_H  = 240;
    localparam int unsigned FB_AW = 18;

    localparam int unsigned R_MSB = 7;
    localparam int unsigned R_LSB = 5;
    localparam int unsigned G_MSB = 4;
    localparam int unsigned G_LSB = 2;
    localparam int unsigned B_MSB = 1;
    localparam int unsigned B_LSB = 0;

    localparam int unsigned BAR_W   = 80;
    localparam int unsigned BAR_CNT = 8;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // x_rel / 80 without a divider: highest bar whose left edge is at or below x
    function automatic logic [2:0] bar_index(input logic [9:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < int'(BAR_CNT); i++) begin
            if (x >= 10'(i * int'(BAR_W))) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // White, yellow, cyan, green, magenta, red, blue, black
    function automatic rgb12_t bar_colour(input logic [2:0] idx);
        rgb12_t c;
        case (idx)
            3'd0:    c = '{r: 4'hF, g: 4'hF, b: 4'hF};
            3'd1:    c = '{r: 4'hF, g: 4'hF, b: 4'h0};
            3'd2:    c = '{r: 4'h0, g: 4'hF, b: 4'hF};
            3'd3:    c = '{r: 4'h0, g: 4'hF, b: 4'h0};
            3'd4:    c = '{r: 4'hF, g: 4'h0, b: 4'hF};
            3'd5:    c = '{r: 4'hF, g: 4'h0, b: 4'h0};
            3'd6:    c = '{r: 4'h0, g: 4'h0, b: 4'hF};
            default: c = '{r: 4'h0, g: 4'h0, b: 4'h0};
        endcase
        return c;
    endfunction

    // Replicate the top bits so full-scale 3/2-bit values map to 4'hF
    function automatic rgb12_t rgb332_expand(input logic [7:0] d);
        rgb12_t c;
        c.r = {d[R_MSB:R_LSB], d[R_MSB]};
        c.g = {d[G_MSB:G_LSB], d[G_MSB]};
        c.b = {d[B_MSB:B_LSB], d[B_MSB:B_LSB]};
        return c;
    endfunction

endpackage

// File: rtl/test_bars.sv
// Combinational colour-bar generator.
//   x_rel : horizontal position relative to the first active pixel
//   rgb   : 12-bit bar colour for that position
module test_bars
    import vga_pkg::*;
(
    input  logic [9:0] x_rel,
    output rgb12_t     rgb
);

    always_comb begin
        rgb = bar_colour(bar_index(x_rel));
    end

endmodule

// File: rtl/pixel_fetch.sv
// Two-stage pixel pipeline: framebuffer read (or test bars) to VGA colour,
// with page flipping and a completed-frame counter.
//   clk, rst                   : clock, synchronous active-high reset
//   pix_clk                    : one-clk pixel strobe; pipeline advances on it
//   pix_x, pix_y, h_sync, v_sync, draw_active, screen_end : timing inputs
//   test_en                    : show colour bars instead of framebuffer data
//   swap_req / swap_ack        : page flip request / one-clk flip pulse
//   mem_re, mem_addr, mem_rdata: framebuffer read port (data one clk after re)
//   vga_r/g/b, vga_hs, vga_vs, vga_de : aligned video outputs
//   front_page, frame_cnt      : page being scanned, completed frames
module pixel_fetch
    import vga_pkg::*;
#(
    parameter int unsigned H_DRAW_MIN = vga_pkg::H_DRAW_MIN,
    parameter int unsigned FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_clk,
    input  logic [9:0]        pix_x,
    input  logic [8:0]        pix_y,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic              draw_active,
    input  logic              screen_end,
    input  logic              test_en,
    input  logic              swap_req,
    output logic              mem_re,
    output logic [FB_AW-1:0]  mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              front_page,
    output logic              swap_ack,
    output logic [FCNT_W-1:0] frame_cnt
);

    logic [9:0] x_rel;
    logic       pix_valid;

    // Stage 1 state
    logic       s1_valid;
    logic       s1_test;
    logic [9:0] s1_x_rel;
    logic       s1_hs;
    logic       s1_vs;
    logic       s1_de;

    // Read data is caught the clk after mem_re and held for the next strobe
    logic       re_d;
    logic [7:0] rdata_q;

    rgb12_t     bar_rgb;
    rgb12_t     colour_q;

    logic       unused_y_lsb;

    assign x_rel        = pix_x - 10'(H_DRAW_MIN);
    assign pix_valid    = draw_active && (x_rel < 10'(ACTIVE_W));
    assign unused_y_lsb = pix_y[0];

    test_bars u_test_bars (
        .x_rel (s1_x_rel),
        .rgb   (bar_rgb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            s1_valid   <= 1'b0;
            s1_test    <= 1'b0;
            s1_x_rel   <= '0;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_de      <= 1'b0;
            re_d       <= 1'b0;
            rdata_q    <= '0;
            colour_q   <= '0;
            vga_hs     <= 1'b1;
            vga_vs     <= 1'b1;
            vga_de     <= 1'b0;
            front_page <= 1'b0;
            swap_ack   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            mem_re   <= 1'b0;
            swap_ack <= 1'b0;
            re_d     <= mem_re;
            if (re_d) begin
                rdata_q <= mem_rdata;
            end

            if (pix_clk) begin
                // Stage 1: issue read and register position, syncs and mode
                s1_valid <= pix_valid;
                s1_test  <= test_en;
                s1_x_rel <= x_rel;
                s1_hs    <= h_sync;
                s1_vs    <= v_sync;
                s1_de    <= draw_active;
                if (pix_valid && !test_en) begin
                    mem_re   <= 1'b1;
                    mem_addr <= {front_page, pix_y[8:1], x_rel[9:1]};
                end

                // Stage 2: colour and delayed syncs leave together
                vga_hs <= s1_hs;
                vga_vs <= s1_vs;
                vga_de <= s1_de;
                if (!s1_valid) begin
                    colour_q <= '0;
                end else if (s1_test) begin
                    colour_q <= bar_rgb;
                end else begin
                    colour_q <= rgb332_expand(rdata_q);
                end

                if (screen_end) begin
                    frame_cnt <= frame_cnt + FCNT_W'(1);
                    if (swap_req) begin
                        front_page <= ~front_page;
                        swap_ack   <= 1'b1;
                    end
                end
            end
        end
    end

    assign vga_r = colour_q.r;
    assign vga_g = colour_q.g;
    assign vga_b = colour_q.b;

endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameters SHALL be: H_DRAW_MIN, 160, first active h position; FCNT_W, 16, frame counter width.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state changes on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pix_clk  in  1  pixel strobe, one clk wide; pipeline advances only when high.
REQ-006 pix_x  in  10  timing h position (0 outside active window).
REQ-007 pix_y  in  9  timing v position, clamped to 479 in vertical blank.
REQ-008 h_sync, v_sync  in  1 each  timing syncs, active-low.
REQ-009 draw_active  in  1  timing active-window flag.
REQ-010 screen_end  in  1  last position of frame.
REQ-011 test_en  in  1  select internal colour bars instead of memory.
REQ-012 swap_req  in  1  level request from drawer to flip pages.
REQ-013 mem_re  out  1  framebuffer read enable; mem_addr  out  18  read address; mem_rdata  in  8  RGB332 data, valid one clk after mem_re.
REQ-014 vga_r, vga_g, vga_b  out  4 each  colour; vga_hs, vga_vs  out  1  delayed syncs; vga_de  out  1  delayed active flag.
REQ-015 front_page  out  1  page being scanned; swap_ack  out  1  one-clk pulse on flip; frame_cnt  out  FCNT_W  completed frames.

Function
REQ-016 x_rel SHALL be pix_x - H_DRAW_MIN (10 bits); a pixel is valid when draw_active=1 and x_rel<640; otherwise blank.
REQ-017 On pix_clk with a valid pixel, mem_re SHALL pulse for one clk with mem_addr = {front_page, pix_y[8:1], x_rel[9:1]} (320x240, 2x2 pixel doubling).
REQ-018 mem_re SHALL stay 0 on blank pixels, on clks without pix_clk, and whenever test_en=1.
REQ-019 Pipeline SHALL be two pix_clk stages: stage 1 registers address, valid, syncs and x_rel; stage 2 captures mem_rdata or the bar colour.
REQ-020 vga_hs, vga_vs and vga_de SHALL be delayed by exactly two pix_clk strobes, so colour and syncs stay aligned.
REQ-021 RGB332 expansion SHALL be r={d[7:5],d[7]}, g={d[4:2],d[4]}, b={d[1:0],d[1:0]}.
REQ-022 When the delayed valid flag is 0, all colour outputs SHALL be 0.
REQ-023 Test bars SHALL be 8 bars, each 80 px wide, indexed by x_rel[9:0]/80, colours in order white, yellow, cyan, green, magenta, red, blue, black (all 4'hF / 4'h0 per channel).
REQ-024 On a clk with pix_clk=1 and screen_end=1:
  - frame_cnt SHALL increment, wrapping at 2^FCNT_W to 0.
  - If swap_req=1, front_page SHALL toggle and swap_ack SHALL pulse high for that following clk only.
REQ-025 swap_req deasserted before screen_end SHALL cause no flip; swap_req held high SHALL flip once per frame.
REQ-026 test_en changes SHALL take effect at the next pix_clk strobe; no mid-pixel glitch is allowed.

Reset
REQ-027 While rst=1, outputs SHALL be:
  - vga_r/g/b=0, vga_de=0, vga_hs=1, vga_vs=1.
  - mem_re=0, mem_addr=0.
  - front_page=0, swap_ack=0, frame_cnt=0.
  - Both pipeline stages cleared to blank.
REQ-028 rst SHALL take priority over pix_clk, screen_end and swap_req in the same clk; a pending swap is dropped.
REQ-029 After rst falls, the first non-blank colour SHALL appear two pix_clk strobes after the first valid pixel.

Structure
REQ-030 The shared package vga_pkg SHALL hold:
  - H_DRAW_MIN, ACTIVE_W=640, ACTIVE_H=480.
  - FB_W=320, FB_H=240, FB_AW=18.
  - RGB332 field positions and the 8-entry bar colour table.
REQ-031 Colour-bar generation SHALL live in one combinational sub-module, test_bars (x_rel in, 12-bit RGB out); everything else SHALL be in pixel_fetch.

Verification
REQ-032 Bench SHALL check: pix_clk every 4th clk, pix_x=160, pix_y=0, draw_active=1, mem_rdata=8'hE0 -> mem_addr=0 with mem_re, then two strobes later vga_r=4'hF, vga_g=0, vga_b=0, vga_de=1.
REQ-033 Bench SHALL check: pix_x=799, pix_y=479 -> mem_addr={0,8'd239,9'd319}; pix_x=800 -> no mem_re, colour 0.
REQ-034 Bench SHALL check: swap_req=1 held across screen_end -> front_page 0->1, one swap_ack pulse, frame_cnt +1; next frame's addresses carry bit17=1.
REQ-035 Bench SHALL check: test_en=1, x_rel=85 -> mem_re never asserts, output yellow (F,F,0) after two strobes.
REQ-036 Bench SHALL check: rst asserted mid-line with swap_req=1 and screen_end=1 -> all REQ-027 values next clk, no flip, frame_cnt=0.
REQ-037 Bench SHALL check: frame_cnt preset near wrap (FCNT_W=4, 15 frames) -> 16th screen_end gives 0.
